// File: rtl/m_trap_unit_if.sv
// CSR access bus and trap redirect handshake between the core and m_trap_unit.
interface m_trap_unit_if;
  logic        csr_en_i;
  logic        csr_we_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;
  logic        csr_illegal_o;
  logic        trap_req_o;
  logic [31:0] trap_pc_o;
  logic        trap_ack_i;

  // Core / fetch side
  modport master (
    output csr_en_i, csr_we_i, csr_addr_i, csr_wdata_i, trap_ack_i,
    input  csr_rdata_o, csr_illegal_o, trap_req_o, trap_pc_o
  );

  // Trap unit side
  modport slave (
    input  csr_en_i, csr_we_i, csr_addr_i, csr_wdata_i, trap_ack_i,
    output csr_rdata_o, csr_illegal_o, trap_req_o, trap_pc_o
  );
endinterface

// File: rtl/m_trap_unit.sv
// Machine-mode CSR responder and trap sequencer (M-only layout, MEI/MTI/MSI at 11/7/3).
module m_trap_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               irq_ext_i,
  input  logic               irq_timer_i,
  input  logic               irq_soft_i,
  input  logic               boundary_i,
  input  logic [31:0]        pc_i,
  input  logic               exc_valid_i,
  input  logic [4:0]         exc_code_i,
  input  logic               mret_i,
  m_trap_unit_if.slave       bus,
  output logic [31:0]        mret_pc_o
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic MTVEC_MODE_RST = VECTORED_EN & MTVEC_RESET[0];

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t      state;
  logic        mstatus_mie, mstatus_mpie;
  logic        mie_mei, mie_mti, mie_msi;
  logic        mip_mei, mip_mti, mip_msi;
  logic [29:0] mtvec_base;
  logic        mtvec_mode;
  logic [31:0] mepc_q;
  logic        mcause_irq;
  logic [4:0]  mcause_code;

  logic        idle, pend_mei, pend_mti, pend_msi;
  logic        irq_take, exc_take, trap_take, mret_take;
  logic [4:0]  irq_code, trap_code;
  logic [31:0] vec_off, trap_target;
  logic [31:0] csr_rdata;
  logic        csr_mapped, csr_wr;

  assign idle      = (state == S_IDLE);
  assign pend_mei  = mip_mei & mie_mei;
  assign pend_mti  = mip_mti & mie_mti;
  assign pend_msi  = mip_msi & mie_msi;
  assign irq_take  = idle & boundary_i & mstatus_mie & (pend_mei | pend_mti | pend_msi);
  assign exc_take  = idle & exc_valid_i;
  assign trap_take = exc_take | irq_take;
  assign mret_take = idle & mret_i & ~trap_take;
  assign trap_code = exc_take ? exc_code_i : irq_code;

  // Interrupt priority MEI > MSI > MTI
  always_comb begin
    irq_code = 5'd0;
    if (pend_mei)      irq_code = 5'd11;
    else if (pend_msi) irq_code = 5'd3;
    else if (pend_mti) irq_code = 5'd7;
  end

  // Trap target: base, plus 4*code for interrupts in vectored mode
  always_comb begin
    vec_off     = (~exc_take & mtvec_mode) ? {25'b0, irq_code, 2'b00} : '0;
    trap_target = {mtvec_base, 2'b00} + vec_off;
  end

  // CSR read mux and address decode
  always_comb begin
    csr_rdata  = '0;
    csr_mapped = 1'b1;
    case (bus.csr_addr_i)
      CSR_MSTATUS: csr_rdata = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
      CSR_MIE:     csr_rdata = {20'b0, mie_mei, 3'b0, mie_mti, 3'b0, mie_msi, 3'b0};
      CSR_MTVEC:   csr_rdata = {mtvec_base, 1'b0, mtvec_mode};
      CSR_MEPC:    csr_rdata = mepc_q;
      CSR_MCAUSE:  csr_rdata = {mcause_irq, 26'b0, mcause_code};
      CSR_MIP:     csr_rdata = {20'b0, mip_mei, 3'b0, mip_mti, 3'b0, mip_msi, 3'b0};
      default:     csr_mapped = 1'b0;
    endcase
  end

  assign bus.csr_rdata_o   = csr_rdata;
  assign bus.csr_illegal_o = bus.csr_en_i &
                             (~csr_mapped | (bus.csr_we_i & (bus.csr_addr_i == CSR_MIP)));
  assign csr_wr            = bus.csr_en_i & bus.csr_we_i & csr_mapped &
                             (bus.csr_addr_i != CSR_MIP);
  assign mret_pc_o         = mepc_q;

  // mstatus: trap entry and mret override a same-cycle software write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
    end else if (trap_take) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (mret_take) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (csr_wr && bus.csr_addr_i == CSR_MSTATUS) begin
      mstatus_mie  <= bus.csr_wdata_i[3];
      mstatus_mpie <= bus.csr_wdata_i[7];
    end
  end

  // mie and mtvec: software writes only; mode is WARL (2/3 keep the old mode)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_mei    <= 1'b0;
      mie_mti    <= 1'b0;
      mie_msi    <= 1'b0;
      mtvec_base <= MTVEC_RESET[31:2];
      mtvec_mode <= MTVEC_MODE_RST;
    end else if (csr_wr) begin
      if (bus.csr_addr_i == CSR_MIE) begin
        mie_mei <= bus.csr_wdata_i[11];
        mie_mti <= bus.csr_wdata_i[7];
        mie_msi <= bus.csr_wdata_i[3];
      end
      if (bus.csr_addr_i == CSR_MTVEC) begin
        mtvec_base <= bus.csr_wdata_i[31:2];
        if (!VECTORED_EN)
          mtvec_mode <= 1'b0;
        else if (!bus.csr_wdata_i[1])
          mtvec_mode <= bus.csr_wdata_i[0];
      end
    end
  end

  // mepc / mcause: trap entry overrides a same-cycle software write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mepc_q      <= '0;
      mcause_irq  <= 1'b0;
      mcause_code <= '0;
    end else if (trap_take) begin
      mepc_q      <= pc_i & 32'hFFFF_FFFC;
      mcause_irq  <= ~exc_take;
      mcause_code <= trap_code;
    end else if (csr_wr) begin
      if (bus.csr_addr_i == CSR_MEPC)
        mepc_q <= bus.csr_wdata_i & 32'hFFFF_FFFC;
      if (bus.csr_addr_i == CSR_MCAUSE) begin
        mcause_irq  <= bus.csr_wdata_i[31];
        mcause_code <= bus.csr_wdata_i[4:0];
      end
    end
  end

  // mip: one-cycle registered copy of the interrupt lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mip_mei <= 1'b0;
      mip_mti <= 1'b0;
      mip_msi <= 1'b0;
    end else begin
      mip_mei <= irq_ext_i;
      mip_mti <= irq_timer_i;
      mip_msi <= irq_soft_i;
    end
  end

  // Redirect FSM with registered request and target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      bus.trap_req_o <= 1'b0;
      bus.trap_pc_o  <= '0;
    end else begin
      case (state)
        S_IDLE: if (trap_take) begin
          state          <= S_REQ;
          bus.trap_req_o <= 1'b1;
          bus.trap_pc_o  <= trap_target;
        end
        S_REQ: if (bus.trap_ack_i) begin
          state          <= S_IDLE;
          bus.trap_req_o <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/m_trap_unit.md
Name: m_trap_unit

Overview:
- Machine-mode CSR responder and trap sequencer for the RV32 core. Services core CSR accesses to mstatus, mie, mtvec, mepc, mcause and mip, using the M-only field layout (MEI/MTI/MSI at bits 11/7/3).
- Arbitrates exceptions and the external, timer and software interrupt lines.
- Performs trap entry and mret state updates, and drives the PC redirect handshake back to the fetch stage.

Parameters:
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec. mode field must be 0 or 1.
- VECTORED_EN, 1, when 0, mtvec.mode is hard-wired to 0 (direct mode).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- irq_ext_i  in  1  machine external interrupt, level, synchronous to clk
- irq_timer_i  in  1  machine timer interrupt, level
- irq_soft_i  in  1  machine software interrupt, level
- boundary_i  in  1  core is at an instruction boundary; an interrupt may be taken
- pc_i  in  32  PC of the faulting instruction, or of the next instruction when boundary_i=1
- exc_valid_i  in  1  synchronous exception this cycle
- exc_code_i  in  5  exception cause code
- mret_i  in  1  mret retiring this cycle
- csr_en_i  in  1  CSR access strobe
- csr_we_i  in  1  write when csr_en_i=1; full-word write, already merged by the core for set/clear operations
- csr_addr_i  in  12  CSR address
- csr_wdata_i  in  32  write data
- csr_rdata_o  out  32  combinational read data
- csr_illegal_o  out  1  csr_en_i=1 with an unmapped address, or a write to mip
- trap_req_o  out  1  redirect request to the trap target
- trap_pc_o  out  32  trap target, stable while trap_req_o=1
- trap_ack_i  in  1  fetch stage accepted the redirect
- mret_pc_o  out  32  current mepc (combinational), used by the core for the mret redirect

Behaviour:
- Reset (async, rst_n=0):
  - mstatus.MIE=0, mstatus.MPIE=0, mie=0, mtvec=MTVEC_RESET, mepc=0, mcause=0, mip=0.
  - FSM in IDLE, trap_req_o=0, trap_pc_o=0.
  - Reset asserted while in REQ aborts the request immediately.
- CSR map:
  - 0x300 mstatus: MIE bit3 and MPIE bit7 are read/write; MPP bits[12:11] read 2'b11 and ignore writes; all other bits read 0.
  - 0x304 mie: bits 11/7/3 are read/write; others read 0.
  - 0x305 mtvec: base[31:2] is read/write. mode is WARL: a write of 0 or 1 is stored; a write of 2 or 3 keeps the old mode.
  - 0x341 mepc: bits[1:0] read 0.
  - 0x342 mcause: stores bit31 and code[4:0]; code[30:5] read 0.
  - 0x344 mip: read-only.
  - Unmapped addresses read 0 and raise csr_illegal_o. Writes take effect at the next clock edge.
- mip: registered from the irq inputs every cycle, 1-cycle latency; meip=bit11, mtip=bit7, msip=bit3.
- pending = mip & mie. irq_take = IDLE & boundary_i & mstatus.MIE & (pending != 0).
- Interrupt priority: MEI (code 11) > MSI (code 3) > MTI (code 7).
- exc_take = IDLE & exc_valid_i. The exception is taken regardless of MIE. When exc_take and irq_take coincide, the exception wins.
- Trap entry, on the edge following the take cycle:
  - mepc <= pc_i with bits[1:0] cleared.
  - mcause <= {is_irq, 26'b0, code}.
  - MPIE <= MIE, MIE <= 0.
  - FSM goes to REQ; trap_req_o=1.
  - trap_pc_o = {base, 2'b00}. In vectored mode for interrupts, trap_pc_o = {base, 2'b00} + 4*code. Exceptions always use base.
- REQ state: trap_req_o and trap_pc_o are held until trap_ack_i=1, then the FSM returns to IDLE on the next edge. While in REQ, exc_valid_i, interrupts and mret_i are ignored. trap_ack_i while in IDLE is ignored.
- mret, when mret_i is high in IDLE with no trap taken that cycle: MIE <= MPIE, MPIE <= 1.
- Simultaneous events:
  - Any trap taken in a cycle suppresses mret_i in the same cycle.
  - A CSR write in the same cycle as trap entry or mret: the hardware update wins for mstatus, mepc and mcause; writes to mie and mtvec still apply.
  - An mstatus write that sets MIE takes effect the next cycle; a pending interrupt can then be taken that cycle.

Test Plan:
- Direct mode, MTVEC_RESET=0x100: set mie.MTIE and mstatus.MIE, raise irq_timer_i with boundary_i=1 and pc_i=0x2000 -> trap_req_o=1, trap_pc_o=0x100, mcause=0x80000007, mepc=0x2000, mstatus reads 0x1880 (MIE=0, MPIE=1, MPP=11); trap_ack_i drops trap_req_o on the next cycle.
- Vectored mode, mtvec written 0x401: raise irq_ext_i and irq_soft_i together -> cause 11 is taken, trap_pc_o=0x42C; a second interrupt is not taken while MIE=0.
- exc_valid_i with code 2 and an enabled pending interrupt in the same cycle, pc_i=0x3006 -> mcause=0x00000002, mepc=0x3004, trap_pc_o=base.
- After a trap, pulse mret_i -> MIE=1, MPIE=1, mret_pc_o equals mepc; mret_i in the same cycle as exc_valid_i -> mstatus follows trap entry only.
- Write mtvec=0x203 -> mtvec reads back 0x200 with the previous mode preserved. Read 0x7C0 -> rdata=0, csr_illegal_o=1. Write mip -> csr_illegal_o=1 and no state change.
- Assert rst_n=0 while in REQ -> trap_req_o=0 immediately, all CSRs return to their reset values.
